// File: rtl/tt_accum_pkg.sv
// Shared types for the byte-serial accumulator: operation codes and FSM states.
package tt_accum_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_SUB   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EXEC    = 2'd1,
    EMIT    = 2'd2
  } state_e;

endpackage

// File: rtl/tt_accum_alu.sv
// Combinational accumulator datapath: applies one operation to the accumulator.
// Optional build macro ACCUM_SATURATE_EN: ADD overflow clamps to all-ones and
// SUB underflow clamps to zero instead of wrapping; flag reports the clamp.
module tt_accum_alu
  import tt_accum_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  op_e              op,
  output logic [WIDTH-1:0] next_acc,
  output logic             flag
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  // One extra bit catches the carry-out of ADD and the borrow of SUB.
  assign sum_s  = {1'b0, acc} + {1'b0, opnd};
  assign diff_s = {1'b0, acc} - {1'b0, opnd};

  // Select the new accumulator value and the carry/borrow flag for the operation.
  always_comb begin
    next_acc = acc;
    flag     = 1'b0;
    case (op)
      OP_ADD: begin
        flag = sum_s[WIDTH];
`ifdef ACCUM_SATURATE_EN
        if (sum_s[WIDTH]) begin
          next_acc = {WIDTH{1'b1}};
        end else begin
          next_acc = sum_s[WIDTH-1:0];
        end
`else
        next_acc = sum_s[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        flag = diff_s[WIDTH];
`ifdef ACCUM_SATURATE_EN
        if (diff_s[WIDTH]) begin
          next_acc = {WIDTH{1'b0}};
        end else begin
          next_acc = diff_s[WIDTH-1:0];
        end
`else
        next_acc = diff_s[WIDTH-1:0];
`endif
      end
      OP_LOAD:  next_acc = opnd;
      OP_CLEAR: next_acc = {WIDTH{1'b0}};
      default: begin
        next_acc = acc;
        flag     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/tt_byte_serial_accum.sv
// Byte-serial WIDTH-bit accumulator for the 8-bit TinyTapeout pin buses.
// Operands arrive LSB-first over a valid/ready byte stream, the accumulator
// is updated in a single EXEC cycle, and the result leaves LSB-first.
// Build macro ACCUM_SATURATE_EN (handled inside tt_accum_alu) selects clamping.
module tt_byte_serial_accum
  import tt_accum_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  input  logic [1:0] in_op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       ovf
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CNT_W  = $clog2(NBYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] opnd_r, opnd_s;
  op_e              op_r, op_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic             ovf_r, ovf_s;
  logic             in_ready_r, in_ready_s;
  logic             out_valid_r, out_valid_s;
  logic [7:0]       out_byte_r, out_byte_s;
  logic [WIDTH-1:0] alu_acc_s;
  logic             alu_flag_s;

  // Byte idx of a WIDTH-bit word, idx counted from the least significant byte.
  function automatic logic [7:0] byte_at(input logic [WIDTH-1:0] word,
                                         input logic [CNT_W-1:0] idx);
    return 8'(word >> {idx, 3'b000});
  endfunction

  tt_accum_alu #(.WIDTH(WIDTH)) u_alu (
    .acc      (acc_r),
    .opnd     (opnd_r),
    .op       (op_r),
    .next_acc (alu_acc_s),
    .flag     (alu_flag_s)
  );

  // Next-state logic: collect operand bytes, execute once, then stream the result out.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    opnd_s      = opnd_r;
    op_s        = op_r;
    acc_s       = acc_r;
    ovf_s       = ovf_r;
    in_ready_s  = in_ready_r;
    out_valid_s = out_valid_r;
    out_byte_s  = out_byte_r;
    case (state_r)
      COLLECT: begin
        if (in_valid) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (cnt_r == CNT_W'(b)) begin
              opnd_s[8*b +: 8] = in_byte;
            end else begin
              opnd_s[8*b +: 8] = opnd_r[8*b +: 8];
            end
          end
          // The operation travels with the first byte only; later in_op values are ignored.
          if (cnt_r == {CNT_W{1'b0}}) begin
            op_s = op_e'(in_op);
          end else begin
            op_s = op_r;
          end
          if (cnt_r == LAST_IDX) begin
            state_s    = EXEC;
            cnt_s      = {CNT_W{1'b0}};
            in_ready_s = 1'b0;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end else begin
          state_s = COLLECT;
        end
      end
      EXEC: begin
        acc_s = alu_acc_s;
        // LOAD and CLEAR restart the sticky flag; ADD/SUB accumulate into it.
        if ((op_r == OP_LOAD) || (op_r == OP_CLEAR)) begin
          ovf_s = 1'b0;
        end else begin
          ovf_s = ovf_r | alu_flag_s;
        end
        state_s     = EMIT;
        cnt_s       = {CNT_W{1'b0}};
        out_valid_s = 1'b1;
        out_byte_s  = alu_acc_s[7:0];
      end
      EMIT: begin
        if (out_ready) begin
          if (cnt_r == LAST_IDX) begin
            state_s     = COLLECT;
            cnt_s       = {CNT_W{1'b0}};
            out_valid_s = 1'b0;
            in_ready_s  = 1'b1;
          end else begin
            cnt_s      = cnt_r + 1'b1;
            out_byte_s = byte_at(acc_r, cnt_r + 1'b1);
          end
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s     = COLLECT;
        cnt_s       = {CNT_W{1'b0}};
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers; ena=0 freezes everything, rst_n clears asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= COLLECT;
      cnt_r       <= {CNT_W{1'b0}};
      opnd_r      <= {WIDTH{1'b0}};
      op_r        <= OP_ADD;
      acc_r       <= {WIDTH{1'b0}};
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_byte_r  <= 8'h00;
    end else if (ena) begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      opnd_r      <= opnd_s;
      op_r        <= op_s;
      acc_r       <= acc_s;
      ovf_r       <= ovf_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_byte_r  <= out_byte_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_byte  = out_byte_r;
  assign ovf       = ovf_r;

endmodule
